// File: rtl/ahb_lite_master_if.sv
// Single-outstanding AHB-Lite initiator: one valid/ready command becomes one NONSEQ
// transfer, with lane steering, alignment checks and a hung-bus timeout.
module ahb_lite_master_if #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] FIC_0_AHB_M_HADDR,
  output logic [1:0]  FIC_0_AHB_M_HSIZE,
  output logic [1:0]  FIC_0_AHB_M_HTRANS,
  output logic [31:0] FIC_0_AHB_M_HWDATA,
  output logic        FIC_0_AHB_M_HWRITE,
  input  logic [31:0] FIC_0_AHB_M_HRDATA,
  input  logic        FIC_0_AHB_M_HREADY,
  input  logic        FIC_0_AHB_M_HRESP
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic        rdy_seen, rdy_seen_nxt;

  logic        cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [31:0] rsp_rdata_nxt;
  logic [31:0] haddr_nxt, hwdata_nxt;
  logic [1:0]  hsize_nxt, htrans_nxt;
  logic        hwrite_nxt;

  logic        accept, bad_cmd;
  logic [31:0] wdata_steer, rd_shift, rd_lane;

  assign accept = cmd_valid & cmd_ready;

  always_comb begin
    bad_cmd = 1'b0;
    case (cmd_size)
      2'd1:    bad_cmd = cmd_addr[0];
      2'd2:    bad_cmd = |cmd_addr[1:0];
      2'd3:    bad_cmd = 1'b1;
      default: bad_cmd = 1'b0;
    endcase
  end

  // Write data is replicated across every lane the transfer size could select.
  always_comb begin
    wdata_steer = wdata_q;
    case (FIC_0_AHB_M_HSIZE)
      2'd0:    wdata_steer = {4{wdata_q[7:0]}};
      2'd1:    wdata_steer = {2{wdata_q[15:0]}};
      default: wdata_steer = wdata_q;
    endcase
  end

  assign rd_shift = FIC_0_AHB_M_HRDATA >> {FIC_0_AHB_M_HADDR[1:0], 3'b000};

  always_comb begin
    rd_lane = rd_shift;
    case (FIC_0_AHB_M_HSIZE)
      2'd0:    rd_lane = {24'h0, rd_shift[7:0]};
      2'd1:    rd_lane = {16'h0, rd_shift[15:0]};
      default: rd_lane = rd_shift;
    endcase
  end

  always_comb begin
    state_nxt       = state;
    wdata_nxt       = wdata_q;
    wait_cnt_nxt    = wait_cnt;
    rdy_seen_nxt    = rdy_seen;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    haddr_nxt       = FIC_0_AHB_M_HADDR;
    hsize_nxt       = FIC_0_AHB_M_HSIZE;
    htrans_nxt      = FIC_0_AHB_M_HTRANS;
    hwdata_nxt      = FIC_0_AHB_M_HWDATA;
    hwrite_nxt      = FIC_0_AHB_M_HWRITE;

    case (state)
      IDLE: begin
        if (accept) begin
          rsp_rdata_nxt   = 32'h0;
          rsp_err_nxt     = 1'b0;
          rsp_timeout_nxt = 1'b0;
          if (bad_cmd) begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            state_nxt     = RESP;
          end else begin
            haddr_nxt  = cmd_addr;
            hsize_nxt  = cmd_size;
            hwrite_nxt = cmd_write;
            wdata_nxt  = cmd_wdata;
            htrans_nxt = HT_NONSEQ;
            state_nxt  = ADDR;
          end
        end
      end
      ADDR: begin
        if (FIC_0_AHB_M_HREADY) begin
          htrans_nxt   = HT_IDLE;
          hwdata_nxt   = wdata_steer;
          wait_cnt_nxt = '0;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        // HRESP is only meaningful alongside HREADY; the first ERROR cycle is ignored.
        if (FIC_0_AHB_M_HREADY) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = FIC_0_AHB_M_HRESP;
          rsp_rdata_nxt = (!FIC_0_AHB_M_HRESP && !FIC_0_AHB_M_HWRITE) ? rd_lane : 32'h0;
          state_nxt     = RESP;
        end else if (TIMEOUT != 0 && wait_cnt == CW'(TIMEOUT)) begin
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = 32'h0;
          rdy_seen_nxt    = 1'b0;
          state_nxt       = DRAIN;
        end else if (wait_cnt != '1) begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      DRAIN: begin
        // The abandoned data phase must still finish on the bus before we reuse it.
        rdy_seen_nxt = rdy_seen | FIC_0_AHB_M_HREADY;
        if (rsp_valid && rsp_ready) rsp_valid_nxt = 1'b0;
        if ((rdy_seen || FIC_0_AHB_M_HREADY) && (!rsp_valid || rsp_ready))
          state_nxt = IDLE;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    cmd_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      wdata_q            <= 32'h0;
      wait_cnt           <= '0;
      rdy_seen           <= 1'b0;
      cmd_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_rdata          <= 32'h0;
      rsp_err            <= 1'b0;
      rsp_timeout        <= 1'b0;
      FIC_0_AHB_M_HADDR  <= 32'h0;
      FIC_0_AHB_M_HSIZE  <= 2'd0;
      FIC_0_AHB_M_HTRANS <= HT_IDLE;
      FIC_0_AHB_M_HWDATA <= 32'h0;
      FIC_0_AHB_M_HWRITE <= 1'b0;
    end else begin
      state              <= state_nxt;
      wdata_q            <= wdata_nxt;
      wait_cnt           <= wait_cnt_nxt;
      rdy_seen           <= rdy_seen_nxt;
      cmd_ready          <= cmd_ready_nxt;
      rsp_valid          <= rsp_valid_nxt;
      rsp_rdata          <= rsp_rdata_nxt;
      rsp_err            <= rsp_err_nxt;
      rsp_timeout        <= rsp_timeout_nxt;
      FIC_0_AHB_M_HADDR  <= haddr_nxt;
      FIC_0_AHB_M_HSIZE  <= hsize_nxt;
      FIC_0_AHB_M_HTRANS <= htrans_nxt;
      FIC_0_AHB_M_HWDATA <= hwdata_nxt;
      FIC_0_AHB_M_HWRITE <= hwrite_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_if.sv
// Bench for ahb_lite_master_if: directed cases plus randomized transfers checked
// against a transaction-level model of lane selection, errors and latency.
module tb_ahb_lite_master_if;
  localparam int T = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] FIC_0_AHB_M_HADDR, FIC_0_AHB_M_HWDATA, FIC_0_AHB_M_HRDATA;
  logic [1:0]  FIC_0_AHB_M_HSIZE, FIC_0_AHB_M_HTRANS;
  logic        FIC_0_AHB_M_HWRITE, FIC_0_AHB_M_HREADY, FIC_0_AHB_M_HRESP;

  int checks = 0;
  int errors = 0;

  ahb_lite_master_if #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .FIC_0_AHB_M_HADDR(FIC_0_AHB_M_HADDR), .FIC_0_AHB_M_HSIZE(FIC_0_AHB_M_HSIZE),
    .FIC_0_AHB_M_HTRANS(FIC_0_AHB_M_HTRANS), .FIC_0_AHB_M_HWDATA(FIC_0_AHB_M_HWDATA),
    .FIC_0_AHB_M_HWRITE(FIC_0_AHB_M_HWRITE), .FIC_0_AHB_M_HRDATA(FIC_0_AHB_M_HRDATA),
    .FIC_0_AHB_M_HREADY(FIC_0_AHB_M_HREADY), .FIC_0_AHB_M_HRESP(FIC_0_AHB_M_HRESP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
    chk({tag, "_htrans"}, 32'(FIC_0_AHB_M_HTRANS), 0);
    chk({tag, "_haddr"}, FIC_0_AHB_M_HADDR, 0);
    chk({tag, "_hsize"}, 32'(FIC_0_AHB_M_HSIZE), 0);
    chk({tag, "_hwrite"}, 32'(FIC_0_AHB_M_HWRITE), 0);
    chk({tag, "_hwdata"}, FIC_0_AHB_M_HWDATA, 0);
  endtask

  // One command end to end. aw/dw: HREADY-low cycles in address/data phase.
  // Called and returns at a negedge.
  task automatic do_txn(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                        input logic [31:0] wd, input int aw, input int dw,
                        input logic err, input logic [31:0] hr);
    logic        bad, to, exp_err, hr_first;
    logic [31:0] exp_rd, exp_wd;
    logic [7:0]  b [4];
    int nb, a, n, cyc, exp_lat, nd;

    bad = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 0);
    to  = !bad && dw > T;
    exp_err = bad || to || err;
    nb = 1 << size;
    a  = int'(addr[1:0]);
    for (int k = 0; k < 4; k++) b[k] = hr[8*k +: 8];
    exp_rd = 0;
    if (!bad && !to && !err && !wr)
      for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = b[a + k];
    for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[8*(l % nb) +: 8];
    exp_lat = bad ? 1 : (to ? 3 + aw + T : 3 + aw + dw);

    cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_size = size; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (n == 20) begin
      chk("accept_bound", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = $urandom;
    cyc = 1;

    if (bad) begin
      chk("bad_htrans", 32'(FIC_0_AHB_M_HTRANS), 0);
    end else begin
      for (int i = 0; i <= aw; i++) begin
        chk("a_htrans", 32'(FIC_0_AHB_M_HTRANS), 2);
        chk("a_haddr", FIC_0_AHB_M_HADDR, addr);
        chk("a_hsize", 32'(FIC_0_AHB_M_HSIZE), 32'(size));
        chk("a_hwrite", 32'(FIC_0_AHB_M_HWRITE), 32'(wr));
        chk("a_rsp_valid", 32'(rsp_valid), 0);
        FIC_0_AHB_M_HREADY = (i == aw);
        @(negedge clk); cyc++;
      end
      nd = to ? T + 1 : dw + 1;
      for (int j = 0; j < nd; j++) begin
        chk("d_htrans", 32'(FIC_0_AHB_M_HTRANS), 0);
        if (wr) chk("d_hwdata", FIC_0_AHB_M_HWDATA, exp_wd);
        chk("d_rsp_valid", 32'(rsp_valid), 0);
        FIC_0_AHB_M_HREADY = !to && (j == dw);
        FIC_0_AHB_M_HRESP  = FIC_0_AHB_M_HREADY ? err : (err ? 1'b1 : 1'($urandom));
        FIC_0_AHB_M_HRDATA = FIC_0_AHB_M_HREADY ? hr : $urandom;
        @(negedge clk); cyc++;
      end
      FIC_0_AHB_M_HREADY = !to;
      FIC_0_AHB_M_HRESP  = 1'b0;
      FIC_0_AHB_M_HRDATA = $urandom;
    end

    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_latency", cyc, exp_lat);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(to));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    if (!bad && !to) chk("wait_cnt", 32'(dut.wait_cnt), dw);

    repeat ($urandom % 3) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
    end

    if (to) begin
      hr_first = 1'($urandom);
      if (hr_first) begin
        FIC_0_AHB_M_HREADY = 1'b1;
        @(negedge clk);
        FIC_0_AHB_M_HREADY = 1'b0;
        chk("drain_cmd_ready_a", 32'(cmd_ready), 0);
        chk("drain_valid", 32'(rsp_valid), 1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("drain_consumed", 32'(rsp_valid), 0);
      chk("drain_htrans", 32'(FIC_0_AHB_M_HTRANS), 0);
      if (!hr_first) begin
        chk("drain_cmd_ready_b", 32'(cmd_ready), 0);
        @(negedge clk);
        chk("drain_cmd_ready_c", 32'(cmd_ready), 0);
        FIC_0_AHB_M_HREADY = 1'b1;
        @(negedge clk);
      end
      chk("drain_exit_ready", 32'(cmd_ready), 1);
      FIC_0_AHB_M_HREADY = 1'b1;
    end else begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("done_valid", 32'(rsp_valid), 0);
      chk("done_cmd_ready", 32'(cmd_ready), 1);
      if (bad) chk("bad_htrans_end", 32'(FIC_0_AHB_M_HTRANS), 0);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 0; cmd_write = 0; cmd_size = 0;
    cmd_wdata = 0; rsp_ready = 1'b0;
    FIC_0_AHB_M_HRDATA = 0; FIC_0_AHB_M_HREADY = 1'b1; FIC_0_AHB_M_HRESP = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_cmd_ready_up", 32'(cmd_ready), 1);

    do_txn(32'h0000_0010, 1'b1, 2'd2, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0);
    do_txn(32'h0000_0013, 1'b0, 2'd0, 32'h0, 0, 0, 1'b0, 32'h1122_3344);
    do_txn(32'h0000_0100, 1'b0, 2'd2, 32'h0, 0, 5, 1'b0, 32'hCAFE_F00D);
    do_txn(32'h0000_0001, 1'b0, 2'd1, 32'h0, 0, 0, 1'b0, 32'h0);
    do_txn(32'h0000_0020, 1'b0, 2'd3, 32'h0, 0, 0, 1'b0, 32'h0);
    do_txn(32'h0000_0040, 1'b0, 2'd2, 32'h0, 0, T + 1, 1'b0, 32'h0);
    do_txn(32'h0000_0044, 1'b1, 2'd2, 32'h1234_5678, 0, 1, 1'b1, 32'h0);
    do_txn(32'h0000_0046, 1'b1, 2'd1, 32'h0000_A55A, 2, 0, 1'b0, 32'h0);

    // Reset in the middle of a data phase abandons the transfer.
    cmd_valid = 1'b1; cmd_addr = 32'h80; cmd_write = 1'b1; cmd_size = 2'd2; cmd_wdata = 32'h5555_AAAA;
    @(negedge clk);
    cmd_valid = 1'b0;
    FIC_0_AHB_M_HREADY = 1'b1;
    @(negedge clk);
    FIC_0_AHB_M_HREADY = 1'b0;
    @(negedge clk);
    chk("mid_htrans", 32'(FIC_0_AHB_M_HTRANS), 0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    reset = 1'b0; FIC_0_AHB_M_HREADY = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("post_rst_valid2", 32'(rsp_valid), 0);
    chk("post_rst_ready", 32'(cmd_ready), 1);

    for (int t = 0; t < 40; t++) begin
      rs = 2'($urandom);
      ra = $urandom & 32'h0000_FFFF;
      if ($urandom % 4 != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      do_txn(ra, 1'($urandom), rs, $urandom, int'($urandom % 4), int'($urandom % 9),
             ($urandom % 4) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
